// File: rtl/switch_debouncer_pkg.sv
// Shared types and board constants for the switch conditioning path.
// Optional feature macro: SWITCH_DEBOUNCER_GLITCH_COUNT_EN (glitch counter).
// Contents: channel count/indices, idle level, per-channel output bundle,
//           board debounce defaults and a saturating 16-bit adder.
package switch_debouncer_pkg;

    localparam int SW_NUM = 3;

    typedef logic [SW_NUM-1:0] SwitchPath;

    localparam int SW_IDX_CH = 0;
    localparam int SW_IDX_CE = 1;
    localparam int SW_IDX_CP = 2;

    localparam logic SW_IDLE_LEVEL = 1'b1;

    // Board values: 1 ms tick from a 100 MHz clk, 10-tick hold.
    localparam int DEBOUNCE_COUNT_DEF    = 10;
    localparam int DEBOUNCE_TICK_DIV_DEF = 100_000;

    typedef struct packed {
        logic level;
        logic press;
        logic rel;
    } sw_chan_t;

    function automatic logic [15:0] sat_add16(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/switch_debouncer_if.sv
// Bundle between the switch pads and the IO controller.
// Optional feature macro: SWITCH_DEBOUNCER_GLITCH_COUNT_EN adds glitchCount.
// Signals: rawIn (pad levels), swLevel (clean level), swPress/swRelease
//          (one-cycle pulses), glitchCount (rejected bounces, optional).
// Modports: master = pad/consumer side, slave = debouncer side.
interface switch_debouncer_if
    import switch_debouncer_pkg::*;
#(
    parameter int NUM_SW = SW_NUM
);

    logic [NUM_SW-1:0] rawIn;
    logic [NUM_SW-1:0] swLevel;
    logic [NUM_SW-1:0] swPress;
    logic [NUM_SW-1:0] swRelease;
`ifdef SWITCH_DEBOUNCER_GLITCH_COUNT_EN
    logic [15:0]       glitchCount;
`endif

    modport master (
        output rawIn,
        input  swLevel,
        input  swPress,
`ifdef SWITCH_DEBOUNCER_GLITCH_COUNT_EN
        input  glitchCount,
`endif
        input  swRelease
    );

    modport slave (
        input  rawIn,
        output swLevel,
        output swPress,
`ifdef SWITCH_DEBOUNCER_GLITCH_COUNT_EN
        output glitchCount,
`endif
        output swRelease
    );

endinterface

// File: rtl/switch_debouncer_channel.sv
// One switch channel: synchroniser chain, stability counter, level, pulses.
// Ports: clk, rst (async, active-low), i_raw (pad), i_tick (shared tick),
//        o_chan (level/press/rel), o_reject (bounce rejected this cycle).
module switch_debounce_channel
    import switch_debouncer_pkg::*;
#(
    parameter int   SYNC_STAGES    = 2,
    parameter int   DEBOUNCE_COUNT = 4,
    parameter logic IDLE_LEVEL     = SW_IDLE_LEVEL
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_raw,
    input  logic     i_tick,
    output sw_chan_t o_chan,
    output logic     o_reject
);

    localparam int            CW       = $clog2(DEBOUNCE_COUNT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_COUNT - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;

    logic w_synced;
    logic w_diff;
    logic w_accept;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign w_diff   = w_synced ^ r_level;
    assign w_accept = w_diff & i_tick & (r_cnt == CNT_LAST);

    // Plain flop chain, nothing between stages.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    // Agreement clears every cycle; only disagreement waits for a tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_level   <= IDLE_LEVEL;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            priority case (1'b1)
                !w_diff: begin
                    r_cnt <= '0;
                end
                w_accept: begin
                    r_level   <= w_synced;
                    r_cnt     <= '0;
                    r_press   <= (w_synced != IDLE_LEVEL);
                    r_release <= (w_synced == IDLE_LEVEL);
                end
                i_tick: begin
                    r_cnt <= r_cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign o_reject     = (r_cnt != '0) & ~w_diff;
    assign o_chan.level = r_level;
    assign o_chan.press = r_press;
    assign o_chan.rel   = r_release;

endmodule

// File: rtl/switch_debouncer.sv
// Synchronise and debounce the CH/CE/CP switch pads for the IO controller.
// Optional feature macro: SWITCH_DEBOUNCER_GLITCH_COUNT_EN (glitchCount).
// Ports: clk, rst (async, active-low), sw_bus (slave): rawIn in,
//        swLevel/swPress/swRelease out, glitchCount out (optional).
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int   NUM_SW         = SW_NUM,
    parameter int   SYNC_STAGES    = 2,
    parameter int   DEBOUNCE_COUNT = 4,
    parameter int   TICK_DIV       = 1,
    parameter logic IDLE_LEVEL     = SW_IDLE_LEVEL
) (
    input  logic               clk,
    input  logic               rst,
    switch_debouncer_if.slave  sw_bus
);

    logic w_tick;

    generate
        if (TICK_DIV > 1) begin : g_presc
            localparam int            PW       = $clog2(TICK_DIV);
            localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

            logic [PW-1:0] r_pre;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_pre <= '0;
                end else if (r_pre == PRE_LAST) begin
                    r_pre <= '0;
                end else begin
                    r_pre <= r_pre + PW'(1);
                end
            end

            assign w_tick = (r_pre == PRE_LAST);
        end else begin : g_nopresc
            assign w_tick = 1'b1;
        end
    endgenerate

    sw_chan_t          w_chan   [NUM_SW];
    logic [NUM_SW-1:0] w_level;
    logic [NUM_SW-1:0] w_press;
    logic [NUM_SW-1:0] w_release;
`ifdef SWITCH_DEBOUNCER_GLITCH_COUNT_EN
    logic [NUM_SW-1:0] w_reject;
`endif

    generate
        for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
            switch_debounce_channel #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_COUNT (DEBOUNCE_COUNT),
                .IDLE_LEVEL     (IDLE_LEVEL)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .i_raw    (sw_bus.rawIn[g]),
                .i_tick   (w_tick),
                .o_chan   (w_chan[g]),
`ifdef SWITCH_DEBOUNCER_GLITCH_COUNT_EN
                .o_reject (w_reject[g])
`else
                .o_reject ()
`endif
            );
        end
    endgenerate

    always_comb begin
        w_level   = '0;
        w_press   = '0;
        w_release = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            w_level[i]   = w_chan[i].level;
            w_press[i]   = w_chan[i].press;
            w_release[i] = w_chan[i].rel;
        end
    end

    assign sw_bus.swLevel   = w_level;
    assign sw_bus.swPress   = w_press;
    assign sw_bus.swRelease = w_release;

`ifdef SWITCH_DEBOUNCER_GLITCH_COUNT_EN
    logic [15:0] w_rej_num;
    logic [15:0] r_glitch;

    // Several channels rejecting together add their count at once.
    always_comb begin
        w_rej_num = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            w_rej_num = w_rej_num + 16'(w_reject[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_glitch <= '0;
        end else begin
            r_glitch <= sat_add16(r_glitch, w_rej_num);
        end
    end

    assign sw_bus.glitchCount = r_glitch;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer: window-based reference model,
// directed scenarios, random bouncing, and a TICK_DIV=4 latency instance.
module tb_switch_debouncer;

    localparam int NSW  = 3;
    localparam int SYNC = 2;
    localparam int DC   = 4;
    localparam int HL   = SYNC + DC + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NSW-1:0] raw  = '1;
    logic [NSW-1:0] raw4 = '1;

    always #5 clk = ~clk;

    switch_debouncer_if #(.NUM_SW(NSW)) if1 ();
    switch_debouncer_if #(.NUM_SW(NSW)) if4 ();

    assign if1.rawIn = raw;
    assign if4.rawIn = raw4;

    switch_debouncer #(
        .NUM_SW         (NSW),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_COUNT (DC),
        .TICK_DIV       (1),
        .IDLE_LEVEL     (1'b1)
    ) dut1 (
        .clk    (clk),
        .rst    (rst),
        .sw_bus (if1)
    );

    switch_debouncer #(
        .NUM_SW         (NSW),
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_COUNT (DC),
        .TICK_DIV       (4),
        .IDLE_LEVEL     (1'b1)
    ) dut4 (
        .clk    (clk),
        .rst    (rst),
        .sw_bus (if4)
    );

    typedef struct {
        int cyc;
        int ch;
        bit press;
    } ev_t;

    ev_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // samp[j] = pad level sampled j edges ago (0 = this edge).
    logic [NSW-1:0] samp [HL];
    logic [NSW-1:0] m_level  = '1;
    int             m_glitch = 0;

    // Reference: a level flips when the last DC synchronised samples
    // (pad delayed by SYNC edges) all disagree with the current level.
    initial begin
        for (int j = 0; j < HL; j++) samp[j] = '1;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                for (int j = 0; j < HL; j++) samp[j] = '1;
                m_level  = '1;
                m_glitch = 0;
            end else begin
                for (int j = HL - 1; j > 0; j--) samp[j] = samp[j-1];
                samp[0] = raw;
                for (int c = 0; c < NSW; c++) begin
                    bit run;
                    run = 1'b1;
                    for (int k = 0; k < DC; k++)
                        if (samp[SYNC+k][c] == m_level[c]) run = 1'b0;
                    if (samp[SYNC][c] == m_level[c] &&
                        samp[SYNC+1][c] != m_level[c] && m_glitch < 65535)
                        m_glitch++;
                    if (run) begin
                        m_level[c] = ~m_level[c];
                        exp_q.push_back('{cyc, c, (m_level[c] == 1'b0)});
                    end
                end
            end
        end
    end

    // Monitor: pops an expected event for every pulse the DUT shows.
    initial begin
        forever begin
            @(negedge clk);
            n_cmp++;
            if (if1.swLevel !== m_level) begin
                n_err++;
                $display("FAIL level cyc=%0d got=%b want=%b",
                         cyc, if1.swLevel, m_level);
            end
`ifdef SWITCH_DEBOUNCER_GLITCH_COUNT_EN
            n_cmp++;
            if (if1.glitchCount !== 16'(m_glitch)) begin
                n_err++;
                $display("FAIL glitch cyc=%0d got=%0d want=%0d",
                         cyc, if1.glitchCount, m_glitch);
            end
`endif
            for (int c = 0; c < NSW; c++) begin
                if (if1.swPress[c] || if1.swRelease[c]) begin
                    n_cmp++;
                    if (if1.swPress[c] && if1.swRelease[c]) begin
                        n_err++;
                        $display("FAIL both_pulses cyc=%0d ch=%0d", cyc, c);
                    end else if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_pulse cyc=%0d ch=%0d press=%0b",
                                 cyc, c, if1.swPress[c]);
                    end else begin
                        ev_t e;
                        e = exp_q.pop_front();
                        if (e.cyc != cyc || e.ch != c ||
                            e.press != if1.swPress[c]) begin
                            n_err++;
                            $display("FAIL pulse got cyc=%0d ch=%0d press=%0b want cyc=%0d ch=%0d press=%0b",
                                     cyc, c, if1.swPress[c], e.cyc, e.ch, e.press);
                        end
                    end
                end
            end
        end
    end

    task automatic apply(input logic [NSW-1:0] v, input int n);
        raw = v;
        repeat (n) @(negedge clk);
        #2;
    endtask

    initial begin
        int hold [NSW];

        repeat (2) @(negedge clk);
        n_cmp++;
        if (if1.swLevel !== 3'b111 || if1.swPress !== 3'b000 ||
            if1.swRelease !== 3'b000) begin
            n_err++;
            $display("FAIL reset_dut1 got lvl=%b prs=%b rel=%b want 111/000/000",
                     if1.swLevel, if1.swPress, if1.swRelease);
        end
        n_cmp++;
        if (if4.swLevel !== 3'b111 || if4.swPress !== 3'b000 ||
            if4.swRelease !== 3'b000) begin
            n_err++;
            $display("FAIL reset_dut4 got lvl=%b prs=%b rel=%b want 111/000/000",
                     if4.swLevel, if4.swPress, if4.swRelease);
        end
        #2;
        rst = 1'b1;

        apply(3'b111, 4);
        apply(3'b110, 12);
        apply(3'b100, 3);
        apply(3'b110, 12);
        apply(3'b010, 20);
        apply(3'b110, 12);
        apply(3'b111, 12);
        apply(3'b000, 12);
        apply(3'b111, 12);

        for (int c = 0; c < NSW; c++) hold[c] = 0;
        for (int i = 0; i < 400; i++) begin
            logic [NSW-1:0] v;
            v = raw;
            for (int c = 0; c < NSW; c++) begin
                if (hold[c] == 0) begin
                    v[c]    = 1'($urandom_range(0, 1));
                    hold[c] = $urandom_range(1, 9);
                end else begin
                    hold[c]--;
                end
            end
            apply(v, 1);
        end
        apply(3'b111, 12);

        raw = 3'b000;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (if1.swLevel !== 3'b111 || if1.swPress !== 3'b000) begin
            n_err++;
            $display("FAIL reset_midcount got lvl=%b prs=%b want 111/000",
                     if1.swLevel, if1.swPress);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        apply(3'b000, 20);
        apply(3'b111, 12);

        for (int t = 0; t < 4; t++) begin
            logic want;
            int   k;
            bit   seen;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            #2;
            want     = ~raw4[0];
            raw4[0]  = want;
            k        = 0;
            seen     = 1'b0;
            while (!seen && k < 40) begin
                @(posedge clk);
                k++;
                @(negedge clk);
                if (if4.swLevel[0] == want) seen = 1'b1;
            end
            n_cmp++;
            if (!seen || k < 15 || k > 18) begin
                n_err++;
                $display("FAIL div4_latency trial=%0d got=%0d edges (seen=%0b) want 15..18",
                         t, k, seen);
            end
            n_cmp++;
            if (seen && ((want == 1'b0 && if4.swPress[0] !== 1'b1) ||
                         (want == 1'b1 && if4.swRelease[0] !== 1'b1))) begin
                n_err++;
                $display("FAIL div4_pulse trial=%0d got prs=%b rel=%b want pulse on ch0",
                         t, if4.swPress, if4.swRelease);
            end
            repeat (6) @(negedge clk);
            #2;
        end

        repeat (4) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_pulses got=%0d left want=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Upstream conditioning stage for the external switch inputs (CH/btnc, CE, CP) that the IO controller samples as sigCH/sigCE/sigCP.
- Synchronises each raw, asynchronous, bouncing pad signal into clk, then debounces it with a per-channel stability counter.
- Drives the clean level plus one-cycle press/release pulses to the IO controller.
- Switches are active-low: idle level is 1.

Parameters:
- NUM_SW, 3, number of switch channels.
- SYNC_STAGES, 2, synchroniser flops per channel, minimum 2.
- DEBOUNCE_COUNT, 4, consecutive ticks a new level must hold before acceptance, minimum 1.
- TICK_DIV, 1, clk cycles per debounce tick (shared prescaler), minimum 1.
- IDLE_LEVEL, 1'b1, reset/idle level of each switch.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- rawIn  in  NUM_SW  unsynchronised pad levels
- swLevel  out  NUM_SW  debounced level; feeds sigCH/sigCE/sigCP
- swPress  out  NUM_SW  one-cycle pulse when swLevel goes IDLE_LEVEL -> ~IDLE_LEVEL
- swRelease  out  NUM_SW  one-cycle pulse when swLevel returns to IDLE_LEVEL
- glitchCount  out  16  only with the optional feature; see below

Behaviour:
- Reset (rst=0, asynchronous):
  - all synchroniser flops and swLevel = IDLE_LEVEL
  - debounce counters, prescaler, swPress, swRelease, glitchCount = 0
- Synchroniser: rawIn passes through a SYNC_STAGES-deep flop chain; the last stage is `synced`. No logic between stages.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 on the cycle the count equals TICK_DIV-1. With TICK_DIV=1, tick is constantly 1.
- Per-channel counter cnt, width $clog2(DEBOUNCE_COUNT+1). Each clk edge, in priority order:
  - synced == swLevel: cnt <= 0, every cycle, not tick-gated.
  - synced != swLevel and tick and cnt == DEBOUNCE_COUNT-1: swLevel <= synced, cnt <= 0, and a pulse is issued:
    - swPress=1 for one cycle if the new level is ~IDLE_LEVEL
    - swRelease=1 for one cycle if the new level is IDLE_LEVEL
  - synced != swLevel and tick, otherwise: cnt <= cnt+1.
  - otherwise: hold.
- Pulses are registered and deassert the following cycle. swPress and swRelease are never both 1 on the same channel.
- Latency, TICK_DIV=1: a raw change held steady is reflected on swLevel exactly SYNC_STAGES+DEBOUNCE_COUNT edges after the first edge that samples it.
- Latency, TICK_DIV>1: between SYNC_STAGES+(DEBOUNCE_COUNT-1)*TICK_DIV+1 and SYNC_STAGES+DEBOUNCE_COUNT*TICK_DIV edges.
- Bounce: any return of synced to swLevel before acceptance clears cnt; the next attempt restarts from 0.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses.
- Reset mid-count: cnt is discarded and swLevel returns to IDLE_LEVEL. A switch held pressed through reset release is re-accepted after full latency, with a swPress pulse.
- The counter cannot overflow: it clears on acceptance, at DEBOUNCE_COUNT-1.

Optional Feature:
- Macro: SWITCH_DEBOUNCER_GLITCH_COUNT_EN.
- Defined:
  - glitchCount port exists.
  - Increments by 1 for each channel-cycle where cnt != 0 and synced == swLevel, i.e. a rejected bounce.
  - If several channels reject in the same cycle, it adds the number of rejecting channels.
  - Saturates at 16'hFFFF; reset 0.
- Undefined: no port, no counter logic; all other behaviour identical.

Decomposition:
- Shared package Types:
  - SW_NUM = 3
  - SwitchPath = logic [SW_NUM-1:0]
  - channel indices SW_IDX_CH=0, SW_IDX_CE=1, SW_IDX_CP=2
  - SW_IDLE_LEVEL = 1'b1
  - DEBOUNCE_COUNT_DEF and DEBOUNCE_TICK_DIV_DEF (board values; 1 ms tick, 10-tick hold)
- Sub-module switch_debounce_channel (synchroniser + cnt + level + pulses for one bit), instantiated NUM_SW times in a generate loop.
- Prescaler and glitch counter stay in the top module.

Test Plan:
- Settings SYNC=2, DC=4, TICK_DIV=1. Hold rawIn[0] 1->0 from edge 0 -> swLevel[0]=0 after edge 6; swPress[0]=1 for exactly that one cycle; other channels stay 1.
- Same settings. rawIn[1]=0 for 3 cycles, then 1 -> swLevel[1] stays 1, no pulses; with the macro, glitchCount=1.
- Same settings. Press, then release rawIn[2] after 20 cycles -> swRelease[2]=1 one cycle, 6 edges after release; swLevel[2]=1.
- All three rawIn fall on the same cycle -> swPress=3'b111 on the same single cycle.
- Settings DC=4, TICK_DIV=4. Hold rawIn[0]=0 -> swLevel[0] changes within 15..18 edges; never earlier.
- rst pulsed low while cnt=2 with rawIn held 0 -> swLevel=111 immediately; after release, swPress fires after full 6-edge latency.
